// File: rtl/bayer_demosaic_pkg.sv
// Shared camera package for the Bayer demosaic slice.
// Holds the CFA phase encodings, the default output window bounds and the
// coordinate width used by the sensor timing counters.
package bayer_demosaic_pkg;

    // Width of the column/row counters supplied by the sensor front end.
    localparam int COORD_W = 12;

    // Colour-filter-array phase of the 2x2 window.
    typedef enum logic [1:0] {
        CFA_RGGB = 2'b00,
        CFA_GRBG = 2'b01,
        CFA_GBRG = 2'b10,
        CFA_BGGR = 2'b11
    } cfa_phase_e;

    // Default exclusive output window (800 x 960 active pixels).
    localparam int DEF_X_START = 239;
    localparam int DEF_X_END   = 1040;
    localparam int DEF_Y_START = 31;
    localparam int DEF_Y_END   = 992;

endpackage

// File: rtl/bayer_demosaic_line_buf.sv
// demosaic_line_buf: one-line delay for the demosaic window.
// Single-port RAM addressed by the column counter. The read is
// combinational and returns the value written one line earlier at the same
// column, so it always sees the old contents (read-before-write).
// Columns at or beyond LINE_W are neither stored nor read (read returns 0).
// Storage is not reset; stale contents are masked downstream.
//
// Ports:
//   clk    in  rising-edge clock
//   en     in  advance enable (sample valid)
//   x      in  column of the current sample (RAM address)
//   wdata  in  current raw sample
//   rdata  out same-column sample from the previous line
module demosaic_line_buf
    import bayer_demosaic_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int LINE_W = 1280
) (
    input  logic                clk,
    input  logic                en,
    input  logic [COORD_W-1:0]  x,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [COORD_W-1:0] LINE_LIM = COORD_W'(LINE_W);

    logic [DATA_W-1:0] mem [0:LINE_W-1];
    logic [ADDR_W-1:0] addr;
    logic              in_range;

    assign addr     = x[ADDR_W-1:0];
    assign in_range = (x < LINE_LIM);
    assign rdata    = in_range ? mem[addr] : '0;

    // Write the current sample so the next line reads it back at this column.
    always_ff @(posedge clk) begin
        if (en && in_range) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/bayer_demosaic.sv
// bayer_demosaic: bilinear-style 2x2 Bayer demosaic with one cycle latency.
// The window is P (current sample), L (same column, previous line) and the
// one-sample-delayed copies Pd and Ld. The CFA phase of the current sample
// selects which tap feeds red/blue and which pair is averaged for green.
//
// Ports:
//   iCLK     in  clock (rising edge)
//   iRST     in  asynchronous active-low reset
//   iDATA    in  raw sensor sample
//   iDVAL    in  sample valid; the pipeline advances only when high
//   iX_Cont  in  column of iDATA
//   iY_Cont  in  row of iDATA
//   iMode    in  0 = odd rows suppressed, 1 = every row output
//   oRed     out demosaiced red
//   oGreen   out demosaiced green
//   oBlue    out demosaiced blue
//   oDVAL    out colour outputs valid
module bayer_demosaic
    import bayer_demosaic_pkg::*;
#(
    parameter int          DATA_W  = 10,
    parameter int          LINE_W  = 1280,
    parameter int          X_START = DEF_X_START,
    parameter int          X_END   = DEF_X_END,
    parameter int          Y_START = DEF_Y_START,
    parameter int          Y_END   = DEF_Y_END,
    parameter logic [1:0]  BAYER   = 2'b00
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [DATA_W-1:0]   iDATA,
    input  logic                iDVAL,
    input  logic [COORD_W-1:0]  iX_Cont,
    input  logic [COORD_W-1:0]  iY_Cont,
    input  logic                iMode,
    output logic [DATA_W-1:0]   oRed,
    output logic [DATA_W-1:0]   oGreen,
    output logic [DATA_W-1:0]   oBlue,
    output logic                oDVAL
);

    localparam logic [COORD_W-1:0] X_LO     = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] X_HI     = COORD_W'(X_END);
    localparam logic [COORD_W-1:0] Y_LO     = COORD_W'(Y_START);
    localparam logic [COORD_W-1:0] Y_HI     = COORD_W'(Y_END);
    localparam logic [COORD_W-1:0] LINE_LIM = COORD_W'(LINE_W);

    // Floor average with one extra bit so the sum cannot overflow.
    function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W:1];
    endfunction

    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] pd_q, pd_d;
    logic [DATA_W-1:0] ld_q, ld_d;
    logic [DATA_W-1:0] red_q, red_d;
    logic [DATA_W-1:0] green_q, green_d;
    logic [DATA_W-1:0] blue_q, blue_d;
    logic              dval_q, dval_d;
    logic              seen_q, seen_d;
    logic              primed_q, primed_d;
    logic [1:0]        ph;
    logic              x_is_zero;
    logic              in_window;

    // P and L are live taps of the current cycle; only their delayed copies
    // are state, which keeps the latency at a single register stage.
    assign p = iDATA;

    demosaic_line_buf #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W)
    ) u_line_buf (
        .clk   (iCLK),
        .en    (iDVAL),
        .x     (iX_Cont),
        .wdata (iDATA),
        .rdata (l)
    );

    assign ph        = {iY_Cont[0] ^ BAYER[1], iX_Cont[0] ^ BAYER[0]};
    assign x_is_zero = (iX_Cont == '0);
    assign in_window = (iX_Cont > X_LO) && (iX_Cont < X_HI) &&
                       (iY_Cont > Y_LO) && (iY_Cont < Y_HI) &&
                       (iX_Cont < LINE_LIM);

    // Everything holds unless a valid sample arrives. primed is only set at
    // a line start that follows earlier data, so the previous line in the
    // buffer belongs to the current run rather than stale RAM contents.
    always_comb begin
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        pd_d     = pd_q;
        ld_d     = ld_q;
        seen_d   = seen_q;
        primed_d = primed_q;
        dval_d   = 1'b0;
        if (iDVAL) begin
            unique case (cfa_phase_e'(ph))
                CFA_RGGB: begin
                    red_d   = ld_q;
                    green_d = avg2(pd_q, l);
                    blue_d  = p;
                end
                CFA_GRBG: begin
                    red_d   = l;
                    green_d = avg2(ld_q, p);
                    blue_d  = pd_q;
                end
                CFA_GBRG: begin
                    red_d   = pd_q;
                    green_d = avg2(ld_q, p);
                    blue_d  = l;
                end
                CFA_BGGR: begin
                    red_d   = p;
                    green_d = avg2(pd_q, l);
                    blue_d  = ld_q;
                end
            endcase
            pd_d     = p;
            ld_d     = l;
            seen_d   = 1'b1;
            primed_d = primed_q | (x_is_zero & seen_q);
            dval_d   = in_window & (iMode | ~iY_Cont[0]) & primed_q & ~x_is_zero;
        end
    end

    // Async reset clears outputs immediately, including oDVAL mid-frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            pd_q     <= '0;
            ld_q     <= '0;
            dval_q   <= 1'b0;
            seen_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            pd_q     <= pd_d;
            ld_q     <= ld_d;
            dval_q   <= dval_d;
            seen_q   <= seen_d;
            primed_q <= primed_d;
        end
    end

    assign oRed   = red_q;
    assign oGreen = green_q;
    assign oBlue  = blue_q;
    assign oDVAL  = dval_q;

endmodule

// File: tb/tb_bayer_demosaic.sv
// Self-checking bench for bayer_demosaic on a reduced frame geometry.
// A frame-level reference model (last written sample per column, previous
// sample, phase table) predicts every output; random frames, a flat field,
// a mode toggle, a data-valid gap and a mid-frame reset are exercised.
module tb_bayer_demosaic;

    localparam int          DW   = 10;
    localparam int          LW   = 32;
    localparam int          XS   = 3;
    localparam int          XE   = 40;
    localparam int          YS   = 1;
    localparam int          YE   = 14;
    localparam int          COLS = 36;
    localparam int          ROWS = 16;
    localparam logic [1:0]  BAY  = 2'b00;

    logic            iCLK = 1'b0;
    logic            iRST = 1'b0;
    logic [DW-1:0]   iDATA = '0;
    logic            iDVAL = 1'b0;
    logic [11:0]     iX_Cont = '0;
    logic [11:0]     iY_Cont = '0;
    logic            iMode = 1'b1;
    logic [DW-1:0]   oRed;
    logic [DW-1:0]   oGreen;
    logic [DW-1:0]   oBlue;
    logic            oDVAL;

    always #5 iCLK = ~iCLK;

    bayer_demosaic #(
        .DATA_W  (DW),
        .LINE_W  (LW),
        .X_START (XS),
        .X_END   (XE),
        .Y_START (YS),
        .Y_END   (YE),
        .BAYER   (BAY)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iDATA   (iDATA),
        .iDVAL   (iDVAL),
        .iX_Cont (iX_Cont),
        .iY_Cont (iY_Cont),
        .iMode   (iMode),
        .oRed    (oRed),
        .oGreen  (oGreen),
        .oBlue   (oBlue),
        .oDVAL   (oDVAL)
    );

    int  errorCount = 0;
    int  checkCount = 0;

    // Reference model state: image rows as seen so far plus the window history.
    int  lineMem [LW];
    int  img [ROWS][COLS];
    int  mPd, mLd;
    bit  mSeen, mPrimed;
    int  expR, expG, expB;
    bit  expDval;
    bit  colourKnown;

    // Observation bookkeeping.
    int  dvalCount;
    bit  watchFirst;
    int  firstX, firstY;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPd = 0; mLd = 0; mSeen = 0; mPrimed = 0;
        expR = 0; expG = 0; expB = 0; expDval = 0;
        colourKnown = 1;
    endtask

    // Predict the registered outputs produced by one presented sample.
    task automatic modelStep(input bit dv, input int x, input int y, input int d, input bit mode);
        int pv, lv, ph;
        if (!dv) begin
            expDval = 0;
            return;
        end
        pv = d;
        lv = (x < LW) ? lineMem[x] : 0;
        ph = (((y % 2) ^ int'(BAY[1])) * 2) + ((x % 2) ^ int'(BAY[0]));
        case (ph)
            0: begin expR = mLd; expG = (mPd + lv) / 2; expB = pv;  end
            1: begin expR = lv;  expG = (mLd + pv) / 2; expB = mPd; end
            2: begin expR = mPd; expG = (mLd + pv) / 2; expB = lv;  end
            default: begin expR = pv; expG = (mPd + lv) / 2; expB = mLd; end
        endcase
        expDval = (x > XS) && (x < XE) && (y > YS) && (y < YE) &&
                  (mode || (y % 2 == 0)) && mPrimed && (x != 0) && (x < LW);
        colourKnown = expDval;
        if (x < LW) lineMem[x] = d;
        if (x == 0 && mSeen) mPrimed = 1;
        mSeen = 1;
        mPd = pv;
        mLd = lv;
    endtask

    // Drive one cycle, advance the model, then check after the active edge.
    task automatic applyStimulus(input bit dv, input int x, input int y, input int d, input bit mode);
        iDVAL   = dv;
        iX_Cont = 12'(x);
        iY_Cont = 12'(y);
        iDATA   = d[DW-1:0];
        iMode   = mode;
        modelStep(dv, x, y, d, mode);
        @(posedge iCLK);
        #1;
        checkOutput("dval", int'(oDVAL), int'(expDval));
        if (colourKnown) begin
            checkOutput("red", int'(oRed), expR);
            checkOutput("green", int'(oGreen), expG);
            checkOutput("blue", int'(oBlue), expB);
        end
        if (oDVAL) dvalCount++;
        if (watchFirst && oDVAL) begin
            firstX = x;
            firstY = y;
            watchFirst = 0;
        end
    endtask

    // kind 0: flat field, 1: random with mode toggle, 2: random with gaps and
    // the directed window, 3: random with a mid-frame reset in half-rate mode.
    task automatic runFrame(input int kind);
        bit mode;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                img[y][x] = (kind == 0) ? 512 : int'($urandom_range(0, (1 << DW) - 1));
        if (kind == 2) begin
            img[3][5] = 400;
            img[3][6] = 300;
            img[4][5] = 201;
            img[4][6] = 100;
        end
        dvalCount = 0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                case (kind)
                    1:       mode = (y > 7) || (y == 7 && x >= 10);
                    3:       mode = 1'b0;
                    default: mode = 1'b1;
                endcase
                if (kind == 2) begin
                    if (y == 5 && x == 12) begin
                        for (int g = 0; g < 5; g++) applyStimulus(1'b0, x, y, 0, mode);
                    end else if ($urandom_range(0, 7) == 0) begin
                        applyStimulus(1'b0, x, y, 0, mode);
                    end
                end
                if (kind == 3 && y == 10 && x == 15) begin
                    iRST = 1'b0;
                    #1;
                    checkOutput("rstDval", int'(oDVAL), 0);
                    checkOutput("rstRed", int'(oRed), 0);
                    checkOutput("rstGreen", int'(oGreen), 0);
                    checkOutput("rstBlue", int'(oBlue), 0);
                    modelReset();
                    @(posedge iCLK);
                    #2;
                    iRST = 1'b1;
                    watchFirst = 1;
                    firstX = -1;
                    firstY = -1;
                end
                applyStimulus(1'b1, x, y, img[y][x], mode);
                if (kind == 2 && y == 4 && x == 6) begin
                    checkOutput("dirRed", int'(oRed), 400);
                    checkOutput("dirGreen", int'(oGreen), 250);
                    checkOutput("dirBlue", int'(oBlue), 100);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < LW; i++) lineMem[i] = 0;
        modelReset();
        watchFirst = 0;
        firstX = -1;
        firstY = -1;
        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("resetDval", int'(oDVAL), 0);
        checkOutput("resetRed", int'(oRed), 0);
        checkOutput("resetGreen", int'(oGreen), 0);
        checkOutput("resetBlue", int'(oBlue), 0);
        iRST = 1'b1;

        runFrame(0);
        // Rows 2..13 valid (primed at row 1), columns 4..31 (line limit 32).
        checkOutput("flatCount", dvalCount, 12 * 28);
        runFrame(1);
        runFrame(2);
        runFrame(3);
        checkOutput("firstRowAfterReset", firstY, 12);
        checkOutput("firstColAfterReset", firstX, 4);
        runFrame(2);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bayer_demosaic.md
BAYER_DEMOSAIC -- requirements
Module: bayer_demosaic

Interface
REQ-001 SHALL have parameter DATA_W, default 10: pixel width of input and colour outputs.
REQ-002 SHALL have parameter LINE_W, default 1280: maximum active pixels per line, which sets the line-buffer depth.
REQ-003 SHALL have parameters X_START/X_END/Y_START/Y_END, defaults 239/1040/31/992: exclusive output window bounds.
REQ-004 SHALL have parameter BAYER, 2 bits, default 2'b00: CFA phase, where bit0 is the column-phase XOR and bit1 is the row-phase XOR.
REQ-005 iCLK  in  1  sole clock; all logic is rising-edge.
REQ-006 iRST  in  1  asynchronous, active-low reset.
REQ-007 iDATA  in  DATA_W  raw sensor sample.
REQ-008 iDVAL  in  1  iDATA valid; pipeline advances only when high.
REQ-009 iX_Cont, iY_Cont  in  12 each  column and row of iDATA.
REQ-010 iMode  in  1  0 = half-rate rows (odd rows suppressed); 1 = every row output.
REQ-011 oRed, oGreen, oBlue  out  DATA_W each  demosaiced colour.
REQ-012 oDVAL  out  1  colour outputs valid.

Function
REQ-013 SHALL form a 2x2 window from current sample P, same-column sample from the previous line L (one-line delay), and one-sample-delayed copies Pd and Ld.
REQ-014 SHALL advance P, Pd, L, Ld and the line buffer only on cycles with iDVAL=1; all SHALL hold otherwise.
REQ-015 SHALL compute phase ph = {iY_Cont[0]^BAYER[1], iX_Cont[0]^BAYER[0]}.
REQ-016 ph=00: R=Ld, G=avg(Pd,L), B=P.
REQ-017 ph=01: R=L, G=avg(Ld,P), B=Pd.
REQ-018 ph=10: R=Pd, G=avg(Ld,P), B=L.
REQ-019 ph=11: R=P, G=avg(Pd,L), B=Ld.
REQ-020 avg SHALL be a DATA_W+1-bit sum right-shifted by 1 (floor); R and B pass unmodified.
REQ-021 Latency SHALL be 1 cycle: colours and oDVAL are registered on the iCLK edge after the completing sample is presented.
REQ-022 oDVAL SHALL be set to iDVAL & (X_START<iX_Cont<X_END) & (Y_START<iY_Cont<Y_END) & (iMode | ~iY_Cont[0]) & primed & (iX_Cont!=0); otherwise 0.
REQ-023 Colour registers SHALL update on every iDVAL cycle regardless of oDVAL, and SHALL hold when iDVAL=0.
REQ-024 The primed flag SHALL be set on an iDVAL cycle with iX_Cont==0 when at least one earlier iDVAL cycle has occurred since reset; once set, it SHALL remain set until reset.
REQ-025 iX_Cont >= LINE_W SHALL not write the line buffer and SHALL force oDVAL=0.
REQ-026 When iX_Cont wraps to 0, window history SHALL not be cleared; oDVAL=0 at column 0 per REQ-022.
REQ-027 Changes to iMode SHALL take effect on the next iDVAL cycle without flushing the pipeline.

Reset
REQ-028 While iRST=0, oRed/oGreen/oBlue/oDVAL, P/Pd/L/Ld, primed, and the seen-data flag SHALL all be 0.
REQ-029 Line-buffer storage SHALL need no reset; stale contents are masked by primed.
REQ-030 Reset asserted mid-frame SHALL force oDVAL=0 within the same cycle (asynchronously); output SHALL resume only after a new line start per REQ-024.

Structure
REQ-031 The CFA-phase encodings (RGGB=00, GRBG=01, GBRG=10, BGGR=11) and the default window constants SHALL live in the shared camera package.
REQ-032 The line delay SHALL be a sub-module demosaic_line_buf (parameters DATA_W, LINE_W): a single-port RAM addressed by iX_Cont with read-before-write, enabled by iDVAL.
REQ-033 Total RTL SHALL be 120-400 lines, with no vendor megafunction instantiation.

Verification
REQ-034 Flat field iDATA=512 on all pixels, iMode=1, 1280x1024 frame -> every oDVAL pixel has R=G=B=512; oDVAL count = 800*960.
REQ-035 BAYER=00, P=100, Pd=201, L=300, Ld=400, ph=00 -> R=400, G=250, B=100; odd sum (Pd=201, L=300) -> G=250 (floor).
REQ-036 iMode=0 -> oDVAL never high on odd iY_Cont; toggle to iMode=1 mid-frame -> odd rows valid from the next iDVAL cycle.
REQ-037 Drop iDVAL for 5 cycles mid-line -> outputs hold, oDVAL=0 during the gap; the post-gap pixel equals the gap-free reference.
REQ-038 Pulse iRST low at row 500, column 600 -> all outputs 0 immediately; oDVAL stays 0 through row 501; valid output resumes at row 502 column 240.
